// File: rtl/sdram_port_scheduler.sv
// Burst scheduler for the four frame-buffer FIFO ports: picks one eligible port, offers a single
// SDRAM burst command and advances that port's wrapping address pointer when the burst completes.
module sdram_port_scheduler #(
  parameter int ADDR_W     = 23,
  parameter int LEN_W      = 8,
  parameter int LVL_W      = 10,
  parameter int FIFO_DEPTH = 512
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4*ADDR_W-1:0]   i_base,
  input  logic [4*ADDR_W-1:0]   i_max,
  input  logic [4*LEN_W-1:0]    i_len,
  input  logic [3:0]            i_load,
  input  logic [4*LVL_W-1:0]    i_level,
  output logic                  o_cmd_valid,
  output logic                  o_cmd_write,
  output logic [1:0]            o_cmd_port,
  output logic [ADDR_W-1:0]     o_cmd_addr,
  output logic [LEN_W-1:0]      o_cmd_len,
  input  logic                  i_cmd_ready,
  input  logic                  i_cmd_done,
  output logic                  o_busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_t;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_ptr [4];
  logic                r_tog_wr, r_tog_rd;
  logic [1:0]          r_port;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;
  logic                r_write;

  logic [ADDR_W-1:0]   w_base [4];
  logic [ADDR_W-1:0]   w_max [4];
  logic [LEN_W-1:0]    w_len [4];
  logic [3:0]          w_elig;
  logic [1:0]          w_gport;
  logic                w_grant, w_advance;
  logic [ADDR_W:0]     w_next;
  logic [ADDR_W-1:0]   w_adv_ptr;

  for (genvar g = 0; g < 4; g++) begin : g_port
    logic [LVL_W-1:0] w_lvl;
    assign w_base[g] = i_base[g*ADDR_W +: ADDR_W];
    assign w_max[g]  = i_max[g*ADDR_W +: ADDR_W];
    assign w_len[g]  = i_len[g*LEN_W +: LEN_W];
    assign w_lvl     = i_level[g*LVL_W +: LVL_W];
    if (g < 2) begin : g_wr
      assign w_elig[g] = 32'(w_lvl) >= 32'(w_len[g]);
    end else begin : g_rd
      // Read side needs room for a full burst; summing avoids underflow when len > depth.
      assign w_elig[g] = (32'(w_lvl) + 32'(w_len[g])) <= 32'(FIFO_DEPTH);
    end
  end

  // Reads beat writes; inside a class the toggle picks which port wins a tie.
  always_comb begin
    w_gport = 2'd0;
    if (w_elig[2] || w_elig[3]) begin
      if (w_elig[2] && w_elig[3]) w_gport = r_tog_rd ? 2'd3 : 2'd2;
      else                        w_gport = w_elig[3] ? 2'd3 : 2'd2;
    end else if (w_elig[0] && w_elig[1]) begin
      w_gport = r_tog_wr ? 2'd1 : 2'd0;
    end else begin
      w_gport = w_elig[1] ? 2'd1 : 2'd0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_advance    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (|w_elig) begin
          w_grant      = 1'b1;
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        if (i_cmd_ready) begin
          if (i_cmd_done) begin
            w_advance    = 1'b1;
            w_state_next = StIdle;
          end else begin
            w_state_next = StWait;
          end
        end
      end
      StWait: begin
        if (i_cmd_done) begin
          w_advance    = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_next    = {1'b0, r_ptr[r_port]} + (ADDR_W+1)'(r_len);
    w_adv_ptr = (w_next >= {1'b0, w_max[r_port]}) ? w_base[r_port] : w_next[ADDR_W-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tog_wr <= 1'b0;
      r_tog_rd <= 1'b0;
      r_port   <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_write  <= 1'b0;
      for (int p = 0; p < 4; p++) r_ptr[p] <= w_base[p];
    end else begin
      if (w_grant) begin
        r_port  <= w_gport;
        r_addr  <= r_ptr[w_gport];
        r_len   <= w_len[w_gport];
        r_write <= ~w_gport[1];
        if (w_gport[1]) r_tog_rd <= ~w_gport[0];
        else            r_tog_wr <= ~w_gport[0];
      end
      // A reload overrides a same-cycle completion advance on that port.
      for (int p = 0; p < 4; p++) begin
        if (i_load[p])                          r_ptr[p] <= w_base[p];
        else if (w_advance && r_port == 2'(p))  r_ptr[p] <= w_adv_ptr;
      end
    end
  end

  assign o_cmd_valid = (r_state == StIssue);
  assign o_busy      = (r_state != StIdle);
  assign o_cmd_write = r_write;
  assign o_cmd_port  = r_port;
  assign o_cmd_addr  = r_addr;
  assign o_cmd_len   = r_len;

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Directed bench: stimulus pushes expected commands into a queue, a monitor pops them on accept.
module tb_sdram_port_scheduler;

  localparam int ADDR_W = 23;
  localparam int LEN_W  = 8;
  localparam int LVL_W  = 10;

  typedef struct packed {
    logic [1:0]        port;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              wr;
  } cmd_t;

  logic                i_clk = 1'b0;
  logic                i_rst = 1'b1;
  logic [ADDR_W-1:0]   base [4];
  logic [ADDR_W-1:0]   maxv [4];
  logic [LEN_W-1:0]    len  [4];
  logic [LVL_W-1:0]    lvl  [4];
  logic [3:0]          i_load = '0;
  logic                i_cmd_ready = 1'b0;
  logic                i_cmd_done = 1'b0;
  logic                o_cmd_valid, o_cmd_write, o_busy;
  logic [1:0]          o_cmd_port;
  logic [ADDR_W-1:0]   o_cmd_addr;
  logic [LEN_W-1:0]    o_cmd_len;

  int   n_checks = 0;
  int   n_errors = 0;
  cmd_t exp_q [$];

  always #5 i_clk = ~i_clk;

  sdram_port_scheduler dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_base      ({base[3], base[2], base[1], base[0]}),
    .i_max       ({maxv[3], maxv[2], maxv[1], maxv[0]}),
    .i_len       ({len[3], len[2], len[1], len[0]}),
    .i_load      (i_load),
    .i_level     ({lvl[3], lvl[2], lvl[1], lvl[0]}),
    .o_cmd_valid (o_cmd_valid),
    .o_cmd_write (o_cmd_write),
    .o_cmd_port  (o_cmd_port),
    .o_cmd_addr  (o_cmd_addr),
    .o_cmd_len   (o_cmd_len),
    .i_cmd_ready (i_cmd_ready),
    .i_cmd_done  (i_cmd_done),
    .o_busy      (o_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted command must match the oldest expectation.
  always @(negedge i_clk) begin
    if (!i_rst && o_cmd_valid && i_cmd_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_cmd_port", 32'(o_cmd_port), 32'hFFFF_FFFF);
      end else begin
        cmd_t e;
        e = exp_q.pop_front();
        chk("cmd_port",  32'(o_cmd_port),  32'(e.port));
        chk("cmd_addr",  32'(o_cmd_addr),  32'(e.addr));
        chk("cmd_len",   32'(o_cmd_len),   32'(e.len));
        chk("cmd_write", 32'(o_cmd_write), 32'(e.wr));
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Levels that leave every port ineligible: empty write FIFOs, full read FIFOs.
  task automatic idle_levels();
    lvl[0] = 0; lvl[1] = 0; lvl[2] = 512; lvl[3] = 512;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_cmd_ready = 1'b0;
    i_cmd_done = 1'b0;
    i_load = '0;
    idle_levels();
    step();
    step();
    i_rst = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!o_cmd_valid && cycles < 20) begin
      step();
      cycles++;
    end
    chk("valid_within_budget", 32'(o_cmd_valid), 32'd1);
  endtask

  task automatic accept(input logic with_done);
    i_cmd_ready = 1'b1;
    i_cmd_done = with_done;
    step();
    i_cmd_ready = 1'b0;
    i_cmd_done = 1'b0;
  endtask

  task automatic finish_burst();
    i_cmd_done = 1'b1;
    step();
    i_cmd_done = 1'b0;
    chk("idle_after_done_valid", 32'(o_cmd_valid), 32'd0);
    chk("idle_after_done_busy", 32'(o_busy), 32'd0);
  endtask

  task automatic run_burst(input cmd_t e);
    int c;
    wait_valid(c);
    exp_q.push_back(e);
    accept(1'b0);
    chk("wait_busy", 32'(o_busy), 32'd1);
    step();
    finish_burst();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    base[0] = 23'h0;      base[1] = 23'h100000; base[2] = 23'h0;      base[3] = 23'h100000;
    maxv[0] = 23'h100000; maxv[1] = 23'h200000; maxv[2] = 23'h100000; maxv[3] = 23'h200000;
    for (int p = 0; p < 4; p++) len[p] = 8'd80;
    do_reset();

    // Reset state
    chk("rst_valid", 32'(o_cmd_valid), 32'd0);
    chk("rst_busy",  32'(o_busy),      32'd0);
    chk("rst_write", 32'(o_cmd_write), 32'd0);
    chk("rst_port",  32'(o_cmd_port),  32'd0);
    chk("rst_addr",  32'(o_cmd_addr),  32'd0);
    chk("rst_len",   32'(o_cmd_len),   32'd0);

    // Priority: read beats write; one-cycle grant latency
    lvl[0] = 80; lvl[2] = 0;
    wait_valid(c);
    chk("grant_latency", 32'(c), 32'd1);
    exp_q.push_back('{port: 2'd2, addr: 23'h0, len: 8'd80, wr: 1'b0});
    accept(1'b0);
    chk("wait_busy", 32'(o_busy), 32'd1);
    chk("wait_valid_low", 32'(o_cmd_valid), 32'd0);
    lvl[2] = 512;
    finish_burst();
    run_burst('{port: 2'd0, addr: 23'h0, len: 8'd80, wr: 1'b1});

    // Round-robin between the two read ports
    do_reset();
    lvl[2] = 0; lvl[3] = 0;
    run_burst('{port: 2'd2, addr: 23'h0,      len: 8'd80, wr: 1'b0});
    run_burst('{port: 2'd3, addr: 23'h100000, len: 8'd80, wr: 1'b0});
    run_burst('{port: 2'd2, addr: 23'd80,     len: 8'd80, wr: 1'b0});
    run_burst('{port: 2'd3, addr: 23'h100050, len: 8'd80, wr: 1'b0});

    // Wrap at max = 160 (exact hit) and max = 150 (overshoot)
    maxv[0] = 23'd160;
    do_reset();
    lvl[0] = 80;
    run_burst('{port: 2'd0, addr: 23'd0,  len: 8'd80, wr: 1'b1});
    run_burst('{port: 2'd0, addr: 23'd80, len: 8'd80, wr: 1'b1});
    run_burst('{port: 2'd0, addr: 23'd0,  len: 8'd80, wr: 1'b1});
    run_burst('{port: 2'd0, addr: 23'd80, len: 8'd80, wr: 1'b1});
    maxv[0] = 23'd150;
    do_reset();
    lvl[0] = 80;
    run_burst('{port: 2'd0, addr: 23'd0,  len: 8'd80, wr: 1'b1});
    run_burst('{port: 2'd0, addr: 23'd80, len: 8'd80, wr: 1'b1});
    run_burst('{port: 2'd0, addr: 23'd0,  len: 8'd80, wr: 1'b1});
    maxv[0] = 23'h100000;

    // Stall with an early (ignored) done, then ready+done together
    do_reset();
    lvl[2] = 0;
    wait_valid(c);
    exp_q.push_back('{port: 2'd2, addr: 23'h0, len: 8'd80, wr: 1'b0});
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(o_cmd_valid), 32'd1);
      chk("stall_port",  32'(o_cmd_port),  32'd2);
      chk("stall_addr",  32'(o_cmd_addr),  32'd0);
      chk("stall_len",   32'(o_cmd_len),   32'd80);
      if (i == 2) i_cmd_done = 1'b1;
      step();
      i_cmd_done = 1'b0;
    end
    accept(1'b1);
    chk("same_cycle_done_valid", 32'(o_cmd_valid), 32'd0);
    chk("same_cycle_done_busy",  32'(o_busy),      32'd0);
    run_burst('{port: 2'd2, addr: 23'd80, len: 8'd80, wr: 1'b0});

    // Reset mid-burst: no pointer advance
    do_reset();
    lvl[2] = 0;
    wait_valid(c);
    exp_q.push_back('{port: 2'd2, addr: 23'h0, len: 8'd80, wr: 1'b0});
    accept(1'b0);
    do_reset();
    chk("midrst_valid", 32'(o_cmd_valid), 32'd0);
    chk("midrst_busy",  32'(o_busy),      32'd0);
    lvl[2] = 0;
    run_burst('{port: 2'd2, addr: 23'h0, len: 8'd80, wr: 1'b0});

    // Load coinciding with done on port 0
    do_reset();
    lvl[0] = 80;
    run_burst('{port: 2'd0, addr: 23'd0, len: 8'd80, wr: 1'b1});
    wait_valid(c);
    exp_q.push_back('{port: 2'd0, addr: 23'd80, len: 8'd80, wr: 1'b1});
    accept(1'b0);
    i_load = 4'b0001;
    i_cmd_done = 1'b1;
    step();
    i_load = '0;
    i_cmd_done = 1'b0;
    chk("load_inflight_addr", 32'(o_cmd_addr), 32'd80);
    chk("load_idle_valid", 32'(o_cmd_valid), 32'd0);
    run_burst('{port: 2'd0, addr: 23'd0, len: 8'd80, wr: 1'b1});

    idle_levels();
    step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
